// File: rtl/mips_pkg.sv
// mips_pkg: shared types and sizing helpers for the multicycle MIPS datapath
package mips_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } muldiv_state_t;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH) + 1;

    // Iteration counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int muldiv_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate, used for magnitudes and result signs
module muldiv_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide producing HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the multiplier magnitude is exhausted.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    import mips_pkg::*;

    localparam int CW = muldiv_cnt_w(WIDTH);

    muldiv_state_t      state, state_n;
    muldiv_op_t         op_q;
    logic [WIDTH-1:0]   a_q, b_q, x;
    logic [2*WIDTH-1:0] y, acc, prod_fix;
    logic [CW-1:0]      cnt;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b, rem_fix, quo_fix;
    logic [WIDTH:0]     rtop, diff;
    logic               is_div, is_sgn;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];

    // Restoring step: remainder gets one extra bit so large unsigned divisors never overflow.
    assign rtop = {acc[2*WIDTH-1:WIDTH], x[WIDTH-1]};
    assign diff = rtop - {1'b0, y[WIDTH-1:0]};

    muldiv_sign_fix #(.N(WIDTH)) u_mag_a (.x(a_q), .neg(is_sgn & a_q[WIDTH-1]), .y(mag_a));
    muldiv_sign_fix #(.N(WIDTH)) u_mag_b (.x(b_q), .neg(is_sgn & b_q[WIDTH-1]), .y(mag_b));
    muldiv_sign_fix #(.N(2*WIDTH)) u_prod (.x(acc), .neg(sign_a ^ sign_b), .y(prod_fix));
    muldiv_sign_fix #(.N(WIDTH)) u_quo (.x(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .y(quo_fix));
    muldiv_sign_fix #(.N(WIDTH)) u_rem (.x(acc[2*WIDTH-1:WIDTH]), .neg(sign_a), .y(rem_fix));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state sequencing and status outputs.
    always_comb begin
        state_n = state;
        busy    = state != IDLE;
        done    = state == DONE;
        case (state)
            IDLE: state_n = start ? PREP : IDLE;
`ifdef MULDIV_EARLY_OUT_EN
            PREP: state_n = (!is_div && mag_b == '0) ? FIX : RUN;
            RUN:  state_n = (cnt == CW'(1) || (!is_div && x[WIDTH-1:1] == '0)) ? FIX : RUN;
`else
            PREP: state_n = RUN;
            RUN:  state_n = (cnt == CW'(1)) ? FIX : RUN;
`endif
            FIX:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= MULT;
            a_q         <= '0;
            b_q         <= '0;
            x           <= '0;
            y           <= '0;
            acc         <= '0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q        <= muldiv_op_t'(op);
                    a_q         <= a;
                    b_q         <= b;
                    div_by_zero <= 1'b0;
                end
                PREP: begin
                    sign_a <= is_sgn & a_q[WIDTH-1];
                    sign_b <= is_sgn & b_q[WIDTH-1];
                    cnt    <= CW'(WIDTH);
                    acc    <= '0;
                    x      <= is_div ? mag_a : mag_b;
                    y      <= {{WIDTH{1'b0}}, is_div ? mag_b : mag_a};
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        acc <= {diff[WIDTH] ? rtop[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]};
                        x   <= x << 1;
                    end else begin
                        if (x[0]) acc <= acc + y;
                        x <= x >> 1;
                        y <= y << 1;
                    end
                end
                FIX: begin
                    if (is_div && b_q == '0) begin
                        hi          <= a_q;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed table of multiply/divide vectors plus busy/reset corner sequences
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Expected done cycle: divides and plain multiplies take WIDTH+3.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
        int n;
        logic [31:0] m;
        n = 0;
        m = (!o[0] && y[31]) ? (~y + 32'd1) : y;
        if (o[1]) return 35;
`ifdef MULDIV_EARLY_OUT_EN
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return 3 + n;
`else
        return 35 + n + 0 * int'(m[0]);
`endif
    endfunction

    // Issues one operation; returns the cycle done was seen (0 = timeout) and whether busy held.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int spur_at, output int cyc, output bit busy_ok);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == spur_at);
            if (c == spur_at) begin
                op = 2'b11; a = 32'd9; b = 32'd3;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        bit bok;
        logic [31:0] h0, l0;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b01, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[7]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
        vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[10] = '{2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
        vecs[11] = '{2'b11, 32'd3,        32'd5,        32'd3,        32'd0,        1'b0};
        vecs[12] = '{2'b11, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[13] = '{2'b01, 32'd0,        32'd12345,    32'd0,        32'd0,        1'b0};
        vecs[14] = '{2'b01, 32'd12345,    32'd1,        32'd0,        32'd12345,    1'b0};

        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, cyc, bok);
            chk($sformatf("v%0d done cycle", i), cyc, exp_lat(vecs[i].op, vecs[i].b));
            chk($sformatf("v%0d busy held", i), {31'd0, bok}, 32'd1);
            chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d busy after", i), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d hi hold", i), hi, vecs[i].hi);
            chk($sformatf("v%0d lo hold", i), lo, vecs[i].lo);
        end

        // Start while busy is ignored.
        run_op(2'b01, 32'd6, 32'd7, 4, cyc, bok);
        chk("spur done cycle", cyc, exp_lat(2'b01, 32'd7));
        chk("spur hi", hi, 32'd0);
        chk("spur lo", lo, 32'd42);
        h0 = hi; l0 = lo;
        cyc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) cyc++;
        end
        chk("spur no second op", cyc, 0);
        chk("spur lo stable", lo, l0);
        chk("spur hi stable", hi, h0);

        // Reset mid-operation aborts.
        @(negedge clk);
        op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset done", {31'd0, done}, 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        rst_n = 1'b1;
        run_op(2'b01, 32'd4, 32'd5, 0, cyc, bok);
        chk("post reset done cycle", cyc, exp_lat(2'b01, 32'd5));
        chk("post reset lo", lo, 32'd20);
        chk("post reset hi", hi, 32'd0);
        chk("post reset busy held", {31'd0, bok}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
